// File: rtl/dwt_block_serializer.sv
// dwt_block_serializer
// Buffers whole 8-row coefficient blocks from the DWT (one block per strobe)
// in DEPTH slots and replays them one row per cycle over a valid/ready stream.
// Optional feature macro: DWT_SER_OVF_CNT_EN builds a saturating 16-bit
// dropped-block counter on ovf_cnt; without it ovf_cnt is tied to zero.
module dwt_block_serializer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dwt_valid,
    input  logic [DATA_W-1:0] outp1,
    input  logic [DATA_W-1:0] outp2,
    input  logic [DATA_W-1:0] outp3,
    input  logic [DATA_W-1:0] outp4,
    input  logic [DATA_W-1:0] outp5,
    input  logic [DATA_W-1:0] outp6,
    input  logic [DATA_W-1:0] outp7,
    input  logic [DATA_W-1:0] outp8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_row,
    output logic              out_last,
    output logic              full,
    output logic              empty,
    output logic              drop,
    output logic [15:0]       ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH][8];
    logic [AW-1:0]     wr_blk;
    logic [AW-1:0]     rd_blk;
    logic [2:0]        rd_row;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              hs;
    logic              hs_last;
    logic              slot_free;
    logic              cap;

    // Handshake / capture decisions and next occupancy.
    // A full buffer still accepts a block when its oldest slot is released
    // by the final-row handshake in the same cycle; occupancy then stays put.
    always_comb begin
        hs        = (cnt != '0) && out_ready;
        hs_last   = hs && (rd_row == 3'd7);
        slot_free = (cnt < DEPTH_C) || hs_last;
        cap       = dwt_valid && slot_free;
        cnt_nxt   = cnt;
        if (cap && !hs_last) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!cap && hs_last) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_blk][rd_row];
    assign out_row   = rd_row;
    assign out_last  = (rd_row == 3'd7);

    // Row storage: whole block written into slot wr_blk on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < unsigned'(DEPTH); b++) begin
                for (int unsigned r = 0; r < 8; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (cap) begin
            mem[wr_blk][0] <= outp1;
            mem[wr_blk][1] <= outp2;
            mem[wr_blk][2] <= outp3;
            mem[wr_blk][3] <= outp4;
            mem[wr_blk][4] <= outp5;
            mem[wr_blk][5] <= outp6;
            mem[wr_blk][6] <= outp7;
            mem[wr_blk][7] <= outp8;
        end
    end

    // Pointers, occupancy, status flags and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_blk <= '0;
            rd_blk <= '0;
            rd_row <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            drop   <= 1'b0;
        end else begin
            if (cap) begin
                wr_blk <= wr_blk + AW'(1);
            end
            if (hs) begin
                rd_row <= rd_row + 3'd1;
                if (hs_last) begin
                    rd_blk <= rd_blk + AW'(1);
                end
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == DEPTH_C);
            empty <= (cnt_nxt == '0);
            drop  <= dwt_valid && !slot_free;
        end
    end

`ifdef DWT_SER_OVF_CNT_EN
    // Saturating count of discarded blocks, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (dwt_valid && !slot_free && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_dwt_block_serializer.sv
// Directed self-checking bench for dwt_block_serializer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dwt_block_serializer;

    logic        clk;
    logic        rst_n;
    logic        dwt_valid;
    logic [63:0] outp1, outp2, outp3, outp4, outp5, outp6, outp7, outp8;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  out_row;
    logic        out_last;
    logic        full;
    logic        empty;
    logic        drop;
    logic [15:0] ovf_cnt;

    int n_tests;
    int n_fail;

`ifdef DWT_SER_OVF_CNT_EN
    localparam logic [15:0] OVF_ONE = 16'd1;
`else
    localparam logic [15:0] OVF_ONE = 16'd0;
`endif

    dwt_block_serializer #(.DEPTH(4), .DATA_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dwt_valid (dwt_valid),
        .outp1     (outp1),
        .outp2     (outp2),
        .outp3     (outp3),
        .outp4     (outp4),
        .outp5     (outp5),
        .outp6     (outp6),
        .outp7     (outp7),
        .outp8     (outp8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .full      (full),
        .empty     (empty),
        .drop      (drop),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Row k of block b: every byte equals k, top byte offset by b.
    function automatic logic [63:0] rowval(input int b, input int k);
        logic [63:0] v;
        v = 64'(k) * 64'h0101_0101_0101_0101 + (64'(b) << 56);
        return v;
    endfunction

    task automatic set_block(input int b);
        outp1 = rowval(b, 0); outp2 = rowval(b, 1);
        outp3 = rowval(b, 2); outp4 = rowval(b, 3);
        outp5 = rowval(b, 4); outp6 = rowval(b, 5);
        outp7 = rowval(b, 6); outp8 = rowval(b, 7);
    endtask

    // Drain with out_ready=1, checking every row of blocks first..first+nblk-1.
    task automatic drain(input string tag, input int first, input int nblk);
        out_ready = 1'b1;
        for (int b = first; b < first + nblk; b++) begin
            for (int k = 0; k < 8; k++) begin
                check({tag, "_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_row"},   64'(out_row),   64'(k));
                check({tag, "_data"},  out_data,       rowval(b, k));
                check({tag, "_last"},  64'(out_last),  64'(k == 7));
                @(negedge clk);
            end
        end
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int e;
        int i;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        dwt_valid = 1'b0;
        out_ready = 1'b0;
        set_block(0);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full",  64'(full), 64'd0);
        check("rst_drop",  64'(drop), 64'd0);
        check("rst_ovf",   64'(ovf_cnt), 64'd0);
        check("rst_data",  out_data, 64'd0);
        check("rst_row",   64'(out_row), 64'd0);
        check("rst_last",  64'(out_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single block, consumer always ready
        set_block(0);
        dwt_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        dwt_valid = 1'b0;
        check("single_notempty", 64'(empty), 64'd0);
        drain("single", 0, 1);

        // Backpressure: ready pattern 1,0,0 repeating
        out_ready = 1'b0;
        set_block(1);
        dwt_valid = 1'b1;
        @(negedge clk);
        dwt_valid = 1'b0;
        e = 0;
        i = 0;
        while (e < 8 && i < 40) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_row",   64'(out_row), 64'(e));
            check("bp_data",  out_data, rowval(1, e));
            out_ready = (i % 3 == 0);
            if (out_ready) e++;
            i++;
            @(negedge clk);
        end
        check("bp_rows_done", 64'(e), 64'd8);
        out_ready = 1'b0;
        check("bp_empty", 64'(empty), 64'd1);

        // Burst of 5 blocks with consumer stalled
        for (int b = 10; b < 15; b++) begin
            set_block(b);
            dwt_valid = 1'b1;
            if (b == 14) check("burst_nodrop_early", 64'(drop), 64'd0);
            @(negedge clk);
        end
        dwt_valid = 1'b0;
        check("burst_drop",  64'(drop), 64'd1);
        check("burst_full",  64'(full), 64'd1);
        check("burst_ovf",   64'(ovf_cnt), 64'(OVF_ONE));
        @(negedge clk);
        check("burst_drop_once", 64'(drop), 64'd0);
        drain("burst", 10, 4);
        out_ready = 1'b0;

        // Full buffer, capture coincident with final-row handshake
        for (int b = 20; b < 24; b++) begin
            set_block(b);
            dwt_valid = 1'b1;
            @(negedge clk);
        end
        dwt_valid = 1'b0;
        check("reuse_full0", 64'(full), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("reuse_b20_data", out_data, rowval(20, k));
            if (k == 7) begin
                set_block(24);
                dwt_valid = 1'b1;
            end
            @(negedge clk);
            dwt_valid = 1'b0;
        end
        check("reuse_nodrop", 64'(drop), 64'd0);
        check("reuse_full1",  64'(full), 64'd1);
        check("reuse_ovf",    64'(ovf_cnt), 64'(OVF_ONE));
        drain("reuse", 21, 4);
        out_ready = 1'b0;

        // Reset mid-block with another block queued
        set_block(30);
        dwt_valid = 1'b1;
        @(negedge clk);
        set_block(31);
        @(negedge clk);
        dwt_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_row3", 64'(out_row), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_row",   64'(out_row), 64'd0);
        check("mrst_data",  out_data, 64'd0);
        check("mrst_empty", 64'(empty), 64'd1);
        check("mrst_full",  64'(full), 64'd0);
        check("mrst_ovf",   64'(ovf_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(out_valid), 64'd0);
        set_block(32);
        dwt_valid = 1'b1;
        @(negedge clk);
        dwt_valid = 1'b0;
        drain("post_rst", 32, 1);
        out_ready = 1'b0;

        // Sustained drops with buffer full
        for (int b = 40; b < 44; b++) begin
            set_block(b);
            dwt_valid = 1'b1;
            @(negedge clk);
        end
`ifdef DWT_SER_OVF_CNT_EN
        repeat (65534) @(negedge clk);
        check("sat_fffe", 64'(ovf_cnt), 64'hFFFE);
        check("sat_drop_held", 64'(drop), 64'd1);
        repeat (3) @(negedge clk);
        check("sat_ffff", 64'(ovf_cnt), 64'hFFFF);
`else
        repeat (3) @(negedge clk);
        check("drops_drop_held", 64'(drop), 64'd1);
        check("drops_ovf_zero", 64'(ovf_cnt), 64'd0);
`endif
        dwt_valid = 1'b0;
        @(negedge clk);
        check("drops_end", 64'(drop), 64'd0);
        check("drops_full", 64'(full), 64'd1);
        drain("drops", 40, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound in case the stimulus never completes.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
